// File: rtl/uart_word_tx.sv
// uart_word_tx: FIFO-buffered 32-bit word UART transmitter, four LSB-first 8N1 frames per word (8E1 when UART_WORD_TX_PARITY_EN is defined)
module uart_word_tx #(
  parameter logic [15:0] CLKS_PER_BIT   = 16'd10417,
  parameter int          FIFO_DEPTH_BIT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [31:0]             wr_data,
  output logic                    full,
  output logic [FIFO_DEPTH_BIT:0] count,
  output logic                    overflow,
  output logic                    busy,
  output logic                    word_done,
  output logic                    Tx_Serial
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
  localparam logic [FIFO_DEPTH_BIT:0] FULL_CNT = (FIFO_DEPTH_BIT + 1)'(DEPTH);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_WORD_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  logic [31:0]               mem_q [DEPTH];
  logic [FIFO_DEPTH_BIT-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_BIT:0]   count_q;
  logic                      overflow_q;
  state_t                    state_q, state_d;
  logic [15:0]               timer_q, timer_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [1:0]                byte_idx_q, byte_idx_d;
  logic [31:0]               shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      done_q, word_done_q;
  logic                      push, pop, done, last;
  assign full      = count_q == FULL_CNT;
  assign push      = wr_en && !full;
  assign last      = timer_q == CLKS_PER_BIT - 16'd1;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign busy      = state_q != IDLE;
  assign word_done = word_done_q;
  assign Tx_Serial = tx_q;
  // Word FIFO: a write while full is dropped and latched as overflow, whatever the reader does
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (FIFO_DEPTH_BIT + 1)'(push) - (FIFO_DEPTH_BIT + 1)'(pop);
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end
  // Frame sequencer: next state, bit timer, byte/bit indices and word hand-off from the FIFO
  always_comb begin
    state_d    = state_q;
    timer_d    = (state_q == IDLE || last) ? 16'd0 : timer_q + 16'd1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop        = 1'b1;
        shift_d    = mem_q[rd_ptr_q];
        byte_idx_d = 2'd0;
        state_d    = START;
      end
      START: if (last) begin
        bit_idx_d = 3'd0;
        state_d   = DATA;
      end
      DATA: if (last) begin
        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_WORD_TX_PARITY_EN
        if (bit_idx_q == 3'd7) state_d = PARITY;
`else
        if (bit_idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: if (last) state_d = STOP;
`endif
      STOP: if (last) begin
        if (byte_idx_q != 2'd3) begin
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = shift_q >> 8;
          state_d    = START;
        end else begin
          done = 1'b1;
          if (count_q != '0) begin
            pop        = 1'b1;
            shift_d    = mem_q[rd_ptr_q];
            byte_idx_d = 2'd0;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Line level for the current state; registered below so the pin never glitches
  always_comb begin
`ifdef UART_WORD_TX_PARITY_EN
    tx_d = state_q == START  ? 1'b0 :
           state_q == DATA   ? shift_q[bit_idx_q] :
           state_q == PARITY ? ^shift_q[7:0] : 1'b1;
`else
    tx_d = state_q == START ? 1'b0 :
           state_q == DATA  ? shift_q[bit_idx_q] : 1'b1;
`endif
  end
  // Sequencer registers; word_done is delayed twice so it lines up with the end of the last stop bit on the pin
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      done_q      <= done;
      word_done_q <= done_q;
    end
  end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: randomized self-checking bench against a word/frame-level reference model
module tb_uart_word_tx;
  localparam logic [15:0] CPB  = 16'd4;
  localparam int          CPBI = 4;
  localparam int          DB   = 2;
  localparam int          DEPTH = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int L = 4 * FB * CPBI;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        full, overflow, busy, word_done, Tx_Serial;
  logic [DB:0] count;
  uart_word_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_BIT(DB)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .count(count),
    .overflow(overflow), .busy(busy), .word_done(word_done), .Tx_Serial(Tx_Serial)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [31:0] mq[$];
  logic [31:0] m_cur;
  bit m_act, m_done, m_ovf, e_tx, e_wd, rec;
  int m_t, cyc, wd_cnt;
  bit line_q[$];
  bit wdl_q[$];
  int done_cyc[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  // Bit k of the serial image of word w: per byte a start bit, 8 data bits LSB first, optional even parity, a stop bit
  function automatic bit frame_bit(input logic [31:0] w, input int k);
    logic [7:0] b;
    int p;
    b = w[8*(k/FB) +: 8];
    p = k % FB;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (p == 9 && FB == 11) return ^b;
    return 1'b1;
  endfunction
  task automatic model_reset();
    mq.delete();
    m_act = 0; m_done = 0; m_ovf = 0; m_t = 0; e_tx = 1; e_wd = 0;
  endtask
  // One clock edge of the reference: a word occupies L cycles after its pop, the pin shows it one cycle later
  task automatic model_step(input bit we, input logic [31:0] wd);
    int pre;
    e_tx = m_act ? frame_bit(m_cur, m_t / CPBI) : 1'b1;
    e_wd = m_done;
    m_done = 0;
    pre = mq.size();
    if (m_act) begin
      if (m_t == L - 1) begin m_done = 1; m_act = 0; end
      else m_t++;
    end
    if (!m_act && pre != 0) begin m_cur = mq.pop_front(); m_act = 1; m_t = 0; end
    if (we) begin
      if (pre < DEPTH) mq.push_back(wd);
      else m_ovf = 1;
    end
  endtask
  task automatic cmp_all();
    check("tx", Tx_Serial, e_tx);
    check("word_done", word_done, e_wd);
    check("busy", busy, m_act);
    check("count", count, mq.size());
    check("full", full, mq.size() == DEPTH);
    check("overflow", overflow, m_ovf);
  endtask
  task automatic tick(input bit we, input logic [31:0] wd);
    wr_en = we;
    wr_data = wd;
    @(posedge clk);
    model_step(we, wd);
    #1;
    cyc++;
    wr_en = 0;
    wr_data = $urandom();
    if (word_done === 1'b1) begin wd_cnt++; done_cyc.push_back(cyc); end
    if (rec) begin line_q.push_back(Tx_Serial); wdl_q.push_back(word_done); end
    cmp_all();
  endtask
  task automatic do_reset();
    reset = 1;
    wr_en = 0;
    @(posedge clk);
    model_reset();
    #1;
    cyc++;
    reset = 0;
    cmp_all();
  endtask
  task automatic drain();
    for (int i = 0; i < 8 * L && (m_act || m_done || mq.size() != 0); i++) tick(0, $urandom());
    tick(0, $urandom());
    check("drain_idle", busy, 1'b0);
  endtask
  // Send one word into an idle transmitter and decode the pin: start latency, bytes, word_done position
  task automatic send_decode(input string tag, input logic [31:0] w);
    int s0, d0;
    logic [7:0] v;
    line_q.delete();
    wdl_q.delete();
    rec = 1;
    tick(1, w);
    for (int i = 0; i < L + 40; i++) tick(0, $urandom());
    rec = 0;
    s0 = -1;
    d0 = -1;
    foreach (line_q[i]) if (s0 < 0 && line_q[i] == 1'b0) s0 = i;
    foreach (wdl_q[i]) if (d0 < 0 && wdl_q[i] == 1'b1) d0 = i;
    check({tag, "_start"}, s0, 2);
    check({tag, "_done"}, d0, 2 + L);
    if (s0 == 2)
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 8; i++) v[i] = line_q[s0 + (b * FB + 1 + i) * CPBI + CPBI / 2];
        check({tag, "_byte"}, v, w[8*b +: 8]);
      end
    check({tag, "_idle"}, busy, 1'b0);
  endtask
  initial begin
    model_reset();
    // 1: quiet line after reset
    do_reset();
    wd_cnt = 0;
    for (int i = 0; i < 100; i++) tick(0, $urandom());
    check("t1_no_done", wd_cnt, 0);
    check("t1_tx", Tx_Serial, 1'b1);
    // 2: single word, byte order and latency
    send_decode("t2", 32'h44332211);
    // 3: six back-to-back writes, sixth dropped
    do_reset();
    wd_cnt = 0;
    done_cyc.delete();
    for (int i = 0; i < 6; i++) tick(1, $urandom());
    check("t3_ovf", overflow, 1'b1);
    check("t3_full", full, 1'b1);
    drain();
    check("t3_words", wd_cnt, 5);
    for (int i = 1; i < done_cyc.size(); i++) check("t3_spacing", done_cyc[i] - done_cyc[i-1], L);
    // 4: write on the same edge the full FIFO is popped
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, $urandom());
    check("t4_full", full, 1'b1);
    for (int i = 0; i < L && !(m_act && m_t == L - 1); i++) tick(0, $urandom());
    check("t4_ovf_before", overflow, 1'b0);
    tick(1, $urandom());
    check("t4_count", count, 3);
    check("t4_ovf", overflow, 1'b1);
    drain();
    // 5: reset during bit 3 of byte 1
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, $urandom());
    for (int i = 0; i < L && !(m_act && m_t == (FB + 4) * CPBI + 1); i++) tick(0, $urandom());
    do_reset();
    check("t5_tx", Tx_Serial, 1'b1);
    check("t5_count", count, 0);
    check("t5_busy", busy, 1'b0);
    wd_cnt = 0;
    for (int i = 0; i < 2 * L; i++) tick(0, $urandom());
    check("t5_no_done", wd_cnt, 0);
    send_decode("t5", $urandom());
`ifdef UART_WORD_TX_PARITY_EN
    // 6: even parity per byte
    send_decode("t6", 32'h00000007);
    check("t6_par0", line_q[2 + 9 * CPBI + CPBI / 2], 1'b1);
    check("t6_par1", line_q[2 + (FB + 9) * CPBI + CPBI / 2], 1'b0);
`endif
    // Random traffic with bursts that overrun the FIFO
    do_reset();
    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 99) < 3, $urandom());
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
